// File: rtl/axi_sdp_ram_pkg.sv
// Shared constants and FSM state types for the AXI simple-dual-port RAM.
// Burst encodings, response codes and read/write FSM state enums.
package axi_sdp_ram_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      R_IDLE,
      R_BURST
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI address generator (FIXED / INCR / WRAP, size clamped to bus).
// i_load latches a burst, i_adv steps to the next beat; o_last flags beat len.
module axi_burst_addr_gen
   import axi_sdp_ram_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int MAX_SIZE = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [1:0]        i_burst,
   input  logic [2:0]        i_size,
   input  logic [7:0]        i_len,
   input  logic              i_adv,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last
);

   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_burst;
   logic [2:0]        r_size;
   logic [7:0]        r_len;
   logic [7:0]        r_cnt;

   logic [ADDR_W-1:0] w_bytes;
   logic [ADDR_W-1:0] w_span;
   logic [ADDR_W-1:0] w_low;
   logic [ADDR_W-1:0] w_inc;
   logic [ADDR_W-1:0] w_next;
   logic [2:0]        w_lsh;
   logic              w_wrap_ok;

   assign w_bytes = {{(ADDR_W-1){1'b0}}, 1'b1} << r_size;

   // WRAP only legal for 2/4/8/16 beats; anything else degrades to INCR
   assign w_wrap_ok = (r_burst == BURST_WRAP) &&
                      ((r_len == 8'd1) || (r_len == 8'd3) ||
                       (r_len == 8'd7) || (r_len == 8'd15));

   always_comb begin
      w_lsh = 3'd4;
      case (r_len)
         8'd1:    w_lsh = 3'd1;
         8'd3:    w_lsh = 3'd2;
         8'd7:    w_lsh = 3'd3;
         default: w_lsh = 3'd4;
      endcase
   end

   assign w_span = w_bytes << w_lsh;
   assign w_low  = r_addr & ~(w_span - 1'b1);
   assign w_inc  = r_addr + w_bytes;

   always_comb begin
      w_next = (r_addr & ~(w_bytes - 1'b1)) + w_bytes;
      if (r_burst == BURST_FIXED)
         w_next = r_addr;
      else if (w_wrap_ok)
         w_next = (w_inc == w_low + w_span) ? w_low : w_inc;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr  <= '0;
         r_burst <= BURST_INCR;
         r_size  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_addr  <= i_addr;
         r_burst <= i_burst;
         r_size  <= (i_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : i_size;
         r_len   <= i_len;
         r_cnt   <= '0;
      end else if (i_adv) begin
         r_addr  <= w_next;
         r_cnt   <= r_cnt + 8'd1;
      end
   end

   assign o_addr = r_addr;
   assign o_last = (r_cnt == r_len);

endmodule

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM primitive: one byte-enabled write port, one
// registered read port (read-first; output holds when i_re is low).
module dual_port_ram #(
   parameter int WIDTH  = 64,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int BE_W   = WIDTH / 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [BE_W-1:0]   i_wbe,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_re)
         r_q <= r_mem[i_raddr];
      if (i_we)
         for (int b = 0; b < BE_W; b++)
            if (i_wbe[b])
               r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/axi_sdp_ram_burst.sv
// AXI4 slave scratchpad RAM with burst address generation and a 2-entry
// R output stage (RAM register + skid) that absorbs r_ready backpressure.
// Ports: axi_clk/axi_resetn, AR/R read channel, AW/W/B write channel.
// Optional AXI_SDP_RAM_ERR_RESP_EN: out-of-range beats give SLVERR.
module axi_sdp_ram_burst
   import axi_sdp_ram_pkg::*;
#(
   parameter  int MEMORY_SIZE_BYTES = 4096,
   parameter  int AXI_DATA_WIDTH    = 64,
   parameter  int AXI_ID_WIDTH      = 8,
   parameter  int AXI_ADDR_WIDTH    = 32,
   localparam int AXI_STRB_WIDTH    = AXI_DATA_WIDTH / 8
) (
   input  logic                      axi_clk,
   input  logic                      axi_resetn,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
   input  logic [1:0]                axi_ar_burst,
   input  logic [2:0]                axi_ar_size,
   input  logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
   input  logic [7:0]                axi_ar_len,
   input  logic                      axi_ar_valid,
   output logic                      axi_ar_ready,
   output logic [AXI_DATA_WIDTH-1:0] axi_r_data,
   output logic [AXI_ID_WIDTH-1:0]   axi_r_id,
   output logic [1:0]                axi_r_resp,
   output logic                      axi_r_last,
   output logic                      axi_r_valid,
   input  logic                      axi_r_ready,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
   input  logic [1:0]                axi_aw_burst,
   input  logic [2:0]                axi_aw_size,
   input  logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
   input  logic [7:0]                axi_aw_len,
   input  logic                      axi_aw_valid,
   output logic                      axi_aw_ready,
   input  logic [AXI_DATA_WIDTH-1:0] axi_w_data,
   input  logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
   input  logic                      axi_w_last,
   input  logic                      axi_w_valid,
   output logic                      axi_w_ready,
   output logic [AXI_ID_WIDTH-1:0]   axi_b_id,
   output logic [1:0]                axi_b_resp,
   output logic                      axi_b_valid,
   input  logic                      axi_b_ready
);

   localparam int MEM_AW  = $clog2(MEMORY_SIZE_BYTES);
   localparam int BYTE_AW = $clog2(AXI_STRB_WIDTH);
   localparam int IDX_W   = MEM_AW - BYTE_AW;
   localparam int WORDS   = MEMORY_SIZE_BYTES / AXI_STRB_WIDTH;

   // ---------------- read side ----------------
   rd_state_e                 r_rd_state, w_rd_next;
   logic [AXI_ID_WIDTH-1:0]   r_ar_id;
   logic [AXI_ADDR_WIDTH-1:0] w_rd_addr;
   logic                      w_rd_last;
   logic                      w_rd_oor;
   logic                      w_ar_hs;
   logic                      w_issue;
   logic [AXI_DATA_WIDTH-1:0] w_ram_q;

   // stage A = RAM output register, stage S = skid
   logic                      r_a_valid, r_a_last, r_a_err;
   logic [AXI_ID_WIDTH-1:0]   r_a_id;
   logic                      r_s_valid, r_s_last, r_s_err;
   logic [AXI_ID_WIDTH-1:0]   r_s_id;
   logic [AXI_DATA_WIDTH-1:0] r_s_data;
   logic [AXI_DATA_WIDTH-1:0] w_a_data;
   logic                      w_out_valid;
   logic                      w_pop;

   assign w_ar_hs = axi_ar_valid && axi_ar_ready;

   // only blocked when both entries are full and nothing drains this cycle
   assign w_issue = (r_rd_state == R_BURST) &&
                    !(r_s_valid && r_a_valid && !axi_r_ready);

   always_comb begin
      w_rd_next    = r_rd_state;
      axi_ar_ready = 1'b0;
      unique case (r_rd_state)
         R_IDLE: begin
            axi_ar_ready = 1'b1;
            if (axi_ar_valid)
               w_rd_next = R_BURST;
         end
         R_BURST: begin
            if (w_issue && w_rd_last)
               w_rd_next = R_IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_rd_state <= R_IDLE;
         r_ar_id    <= '0;
      end else begin
         r_rd_state <= w_rd_next;
         if (w_ar_hs)
            r_ar_id <= axi_ar_id;
      end
   end

   axi_burst_addr_gen #(
      .ADDR_W   (AXI_ADDR_WIDTH),
      .MAX_SIZE (BYTE_AW)
   ) u_ar_gen (
      .i_clk   (axi_clk),
      .i_rst_n (axi_resetn),
      .i_load  (w_ar_hs),
      .i_addr  (axi_ar_addr),
      .i_burst (axi_ar_burst),
      .i_size  (axi_ar_size),
      .i_len   (axi_ar_len),
      .i_adv   (w_issue),
      .o_addr  (w_rd_addr),
      .o_last  (w_rd_last)
   );

   assign w_a_data    = r_a_err ? '0 : w_ram_q;
   assign w_out_valid = r_s_valid || r_a_valid;
   assign w_pop       = w_out_valid && axi_r_ready;

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_a_valid <= 1'b0;
         r_a_last  <= 1'b0;
         r_a_err   <= 1'b0;
         r_a_id    <= '0;
         r_s_valid <= 1'b0;
         r_s_last  <= 1'b0;
         r_s_err   <= 1'b0;
         r_s_id    <= '0;
         r_s_data  <= '0;
      end else begin
         if (w_issue) begin
            r_a_last <= w_rd_last;
            r_a_err  <= w_rd_oor;
            r_a_id   <= r_ar_id;
         end
         if (r_s_valid) begin
            if (w_pop) begin
               // skid drains; A (if any) moves up so RAM can be reissued
               if (r_a_valid) begin
                  r_s_data <= w_a_data;
                  r_s_last <= r_a_last;
                  r_s_err  <= r_a_err;
                  r_s_id   <= r_a_id;
               end else begin
                  r_s_valid <= 1'b0;
               end
               r_a_valid <= w_issue;
            end else begin
               r_a_valid <= r_a_valid || w_issue;
            end
         end else if (r_a_valid && !w_pop && w_issue) begin
            // stalled A parked in skid before RAM output is overwritten
            r_s_valid <= 1'b1;
            r_s_data  <= w_a_data;
            r_s_last  <= r_a_last;
            r_s_err   <= r_a_err;
            r_s_id    <= r_a_id;
            r_a_valid <= 1'b1;
         end else if (r_a_valid && w_pop) begin
            r_a_valid <= w_issue;
         end else begin
            r_a_valid <= r_a_valid || w_issue;
         end
      end
   end

   always_comb begin
      axi_r_valid = w_out_valid;
      axi_r_data  = '0;
      axi_r_id    = '0;
      axi_r_last  = 1'b0;
      axi_r_resp  = RESP_OKAY;
      if (r_s_valid) begin
         axi_r_data = r_s_data;
         axi_r_id   = r_s_id;
         axi_r_last = r_s_last;
         axi_r_resp = r_s_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_a_valid) begin
         axi_r_data = w_a_data;
         axi_r_id   = r_a_id;
         axi_r_last = r_a_last;
         axi_r_resp = r_a_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

   // ---------------- write side ----------------
   wr_state_e                 r_wr_state, w_wr_next;
   logic [AXI_ID_WIDTH-1:0]   r_b_id;
   logic                      r_b_err;
   logic [AXI_ADDR_WIDTH-1:0] w_wr_addr;
   logic                      w_wr_last;
   logic                      w_wr_oor;
   logic                      w_aw_hs;
   logic                      w_w_hs;
   logic [AXI_STRB_WIDTH-1:0] w_be;

   assign w_aw_hs = axi_aw_valid && axi_aw_ready;
   assign w_w_hs  = axi_w_valid && axi_w_ready;
   assign w_be    = w_wr_oor ? '0 : axi_w_strb;

   always_comb begin
      w_wr_next    = r_wr_state;
      axi_aw_ready = 1'b0;
      axi_w_ready  = 1'b0;
      axi_b_valid  = 1'b0;
      case (r_wr_state)
         W_IDLE: begin
            axi_aw_ready = 1'b1;
            if (axi_aw_valid)
               w_wr_next = W_DATA;
         end
         W_DATA: begin
            axi_w_ready = 1'b1;
            if (axi_w_valid && w_wr_last)
               w_wr_next = W_RESP;
         end
         W_RESP: begin
            axi_b_valid = 1'b1;
            if (axi_b_ready)
               w_wr_next = W_IDLE;
         end
         default: w_wr_next = W_IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_wr_state <= W_IDLE;
         r_b_id     <= '0;
         r_b_err    <= 1'b0;
      end else begin
         r_wr_state <= w_wr_next;
         if (w_aw_hs) begin
            r_b_id  <= axi_aw_id;
            r_b_err <= 1'b0;
         end else if (w_w_hs && w_wr_oor) begin
            r_b_err <= 1'b1;
         end
      end
   end

   assign axi_b_id   = r_b_id;
   assign axi_b_resp = r_b_err ? RESP_SLVERR : RESP_OKAY;

   axi_burst_addr_gen #(
      .ADDR_W   (AXI_ADDR_WIDTH),
      .MAX_SIZE (BYTE_AW)
   ) u_aw_gen (
      .i_clk   (axi_clk),
      .i_rst_n (axi_resetn),
      .i_load  (w_aw_hs),
      .i_addr  (axi_aw_addr),
      .i_burst (axi_aw_burst),
      .i_size  (axi_aw_size),
      .i_len   (axi_aw_len),
      .i_adv   (w_w_hs),
      .o_addr  (w_wr_addr),
      .o_last  (w_wr_last)
   );

`ifdef AXI_SDP_RAM_ERR_RESP_EN
   assign w_rd_oor = |(w_rd_addr >> MEM_AW);
   assign w_wr_oor = |(w_wr_addr >> MEM_AW);
`else
   assign w_rd_oor = 1'b0;
   assign w_wr_oor = 1'b0;
`endif

   // ---------------- storage ----------------
   dual_port_ram #(
      .WIDTH  (AXI_DATA_WIDTH),
      .DEPTH  (WORDS),
      .ADDR_W (IDX_W),
      .BE_W   (AXI_STRB_WIDTH)
   ) u_ram (
      .i_clk   (axi_clk),
      .i_we    (w_w_hs),
      .i_waddr (w_wr_addr[MEM_AW-1:BYTE_AW]),
      .i_wdata (axi_w_data),
      .i_wbe   (w_be),
      .i_re    (w_issue),
      .i_raddr (w_rd_addr[MEM_AW-1:BYTE_AW]),
      .o_rdata (w_ram_q)
   );

   // w_last is informational only; upper/lower address bits feed no storage
   logic w_unused;
   assign w_unused = ^{axi_w_last, w_rd_addr, w_wr_addr};

endmodule

// File: tb/tb_axi_sdp_ram_burst.sv
// Directed self-checking bench for axi_sdp_ram_burst (64-bit, 4 KiB).
// Honours AXI_SDP_RAM_ERR_RESP_EN for the out-of-range steps.
module tb_axi_sdp_ram_burst;

   logic        axi_clk = 1'b0;
   logic        axi_resetn;
   logic [31:0] axi_ar_addr;
   logic [1:0]  axi_ar_burst;
   logic [2:0]  axi_ar_size;
   logic [7:0]  axi_ar_id;
   logic [7:0]  axi_ar_len;
   logic        axi_ar_valid;
   logic        axi_ar_ready;
   logic [63:0] axi_r_data;
   logic [7:0]  axi_r_id;
   logic [1:0]  axi_r_resp;
   logic        axi_r_last;
   logic        axi_r_valid;
   logic        axi_r_ready;
   logic [31:0] axi_aw_addr;
   logic [1:0]  axi_aw_burst;
   logic [2:0]  axi_aw_size;
   logic [7:0]  axi_aw_id;
   logic [7:0]  axi_aw_len;
   logic        axi_aw_valid;
   logic        axi_aw_ready;
   logic [63:0] axi_w_data;
   logic [7:0]  axi_w_strb;
   logic        axi_w_last;
   logic        axi_w_valid;
   logic        axi_w_ready;
   logic [7:0]  axi_b_id;
   logic [1:0]  axi_b_resp;
   logic        axi_b_valid;
   logic        axi_b_ready;

   always #5 axi_clk = ~axi_clk;

   axi_sdp_ram_burst dut (
      .axi_clk      (axi_clk),
      .axi_resetn   (axi_resetn),
      .axi_ar_addr  (axi_ar_addr),
      .axi_ar_burst (axi_ar_burst),
      .axi_ar_size  (axi_ar_size),
      .axi_ar_id    (axi_ar_id),
      .axi_ar_len   (axi_ar_len),
      .axi_ar_valid (axi_ar_valid),
      .axi_ar_ready (axi_ar_ready),
      .axi_r_data   (axi_r_data),
      .axi_r_id     (axi_r_id),
      .axi_r_resp   (axi_r_resp),
      .axi_r_last   (axi_r_last),
      .axi_r_valid  (axi_r_valid),
      .axi_r_ready  (axi_r_ready),
      .axi_aw_addr  (axi_aw_addr),
      .axi_aw_burst (axi_aw_burst),
      .axi_aw_size  (axi_aw_size),
      .axi_aw_id    (axi_aw_id),
      .axi_aw_len   (axi_aw_len),
      .axi_aw_valid (axi_aw_valid),
      .axi_aw_ready (axi_aw_ready),
      .axi_w_data   (axi_w_data),
      .axi_w_strb   (axi_w_strb),
      .axi_w_last   (axi_w_last),
      .axi_w_valid  (axi_w_valid),
      .axi_w_ready  (axi_w_ready),
      .axi_b_id     (axi_b_id),
      .axi_b_resp   (axi_b_resp),
      .axi_b_valid  (axi_b_valid),
      .axi_b_ready  (axi_b_ready)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [63:0] wd [16];
   logic [7:0]  ws [16];
   logic [63:0] rd [16];
   logic        rl [16];
   logic [1:0]  rr [16];
   logic [7:0]  rid[16];
   int          rn;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge axi_clk);
      #1;
   endtask

   task automatic aw_send(input logic [31:0] a, input logic [1:0] b,
                          input logic [2:0] s, input logic [7:0] l,
                          input logic [7:0] id);
      int n = 0;
      axi_aw_addr = a; axi_aw_burst = b; axi_aw_size = s;
      axi_aw_len = l; axi_aw_id = id; axi_aw_valid = 1'b1;
      while (!axi_aw_ready && n < 50) begin step(); n++; end
      chk("aw_accept", 64'(axi_aw_ready), 64'd1);
      step();
      axi_aw_valid = 1'b0;
   endtask

   task automatic w_send(input logic [63:0] d, input logic [7:0] st,
                         input logic lst);
      int n = 0;
      axi_w_data = d; axi_w_strb = st; axi_w_last = lst;
      axi_w_valid = 1'b1;
      while (!axi_w_ready && n < 50) begin step(); n++; end
      chk("w_accept", 64'(axi_w_ready), 64'd1);
      step();
      axi_w_valid = 1'b0;
   endtask

   task automatic b_wait(input logic [7:0] id, input logic [1:0] resp);
      int n = 0;
      axi_b_ready = 1'b1;
      while (!axi_b_valid && n < 50) begin step(); n++; end
      chk("b_valid", 64'(axi_b_valid), 64'd1);
      chk("b_id", 64'(axi_b_id), 64'(id));
      chk("b_resp", 64'(axi_b_resp), 64'(resp));
      step();
      axi_b_ready = 1'b0;
   endtask

   task automatic wr_burst(input logic [31:0] a, input logic [1:0] b,
                           input logic [2:0] s, input logic [7:0] l,
                           input logic [7:0] id, input logic [1:0] resp);
      aw_send(a, b, s, l, id);
      for (int i = 0; i <= int'(l); i++)
         w_send(wd[i], ws[i], i == int'(l));
      b_wait(id, resp);
   endtask

   task automatic ar_send(input logic [31:0] a, input logic [1:0] b,
                          input logic [2:0] s, input logic [7:0] l,
                          input logic [7:0] id);
      int n = 0;
      axi_ar_addr = a; axi_ar_burst = b; axi_ar_size = s;
      axi_ar_len = l; axi_ar_id = id; axi_ar_valid = 1'b1;
      while (!axi_ar_ready && n < 50) begin step(); n++; end
      chk("ar_accept", 64'(axi_ar_ready), 64'd1);
      step();
      axi_ar_valid = 1'b0;
   endtask

   // collect beats with r_ready held; rn = cycles spent
   task automatic rd_collect(input int len);
      int k = 0;
      rn = 0;
      axi_r_ready = 1'b1;
      while (k <= len && rn < 100) begin
         if (axi_r_valid) begin
            rd[k] = axi_r_data; rl[k] = axi_r_last;
            rr[k] = axi_r_resp; rid[k] = axi_r_id;
            k++;
         end
         step();
         rn++;
      end
      axi_r_ready = 1'b0;
      chk("r_count", 64'(k), 64'(len + 1));
   endtask

   logic [63:0] exp_w [3];
   logic [63:0] prev;
   logic        have_prev;
   int          k;

   initial begin
      axi_resetn = 1'b0;
      axi_ar_addr = '0; axi_ar_burst = '0; axi_ar_size = '0;
      axi_ar_id = '0; axi_ar_len = '0; axi_ar_valid = 1'b0;
      axi_r_ready = 1'b0;
      axi_aw_addr = '0; axi_aw_burst = '0; axi_aw_size = '0;
      axi_aw_id = '0; axi_aw_len = '0; axi_aw_valid = 1'b0;
      axi_w_data = '0; axi_w_strb = '0; axi_w_last = 1'b0;
      axi_w_valid = 1'b0; axi_b_ready = 1'b0;
      repeat (3) step();
      axi_resetn = 1'b1;
      step();

      // reset state
      chk("rst_ar_ready", 64'(axi_ar_ready), 64'd1);
      chk("rst_aw_ready", 64'(axi_aw_ready), 64'd1);
      chk("rst_r_valid", 64'(axi_r_valid), 64'd0);
      chk("rst_b_valid", 64'(axi_b_valid), 64'd0);
      chk("rst_w_ready", 64'(axi_w_ready), 64'd0);
      chk("rst_r_last", 64'(axi_r_last), 64'd0);
      chk("rst_r_data", axi_r_data, 64'd0);
      chk("rst_b_id", 64'(axi_b_id), 64'd0);

      // INCR 64-bit write + readback, latency N+2, 1 beat/cycle
      for (int i = 0; i < 4; i++) begin
         wd[i] = 64'hA5A5_0000_0000_0020 + 64'(i); ws[i] = 8'hFF;
      end
      wr_burst(32'h100, 2'b01, 3'd3, 8'd3, 8'h11, 2'b00);
      axi_r_ready = 1'b1;
      ar_send(32'h100, 2'b01, 3'd3, 8'd3, 8'h21);
      chk("lat_n1_rvalid", 64'(axi_r_valid), 64'd0);
      step();
      chk("lat_n2_rvalid", 64'(axi_r_valid), 64'd1);
      rd_collect(3);
      chk("incr_consec", 64'(rn), 64'd4);
      chk("incr_rid", 64'(rid[0]), 64'h21);
      chk("incr_rresp", 64'(rr[0]), 64'd0);
      for (int i = 0; i < 4; i++) begin
         chk("incr_data", rd[i], 64'hA5A5_0000_0000_0020 + 64'(i));
         chk("incr_last", 64'(rl[i]), 64'(i == 3));
      end

      // WRAP write from 0x38: 0x38,0x20,0x28,0x30
      for (int i = 0; i < 4; i++) begin
         wd[i] = 64'hB0B0_0000_0000_0000 + 64'(i); ws[i] = 8'hFF;
      end
      wr_burst(32'h38, 2'b10, 3'd3, 8'd3, 8'h5A, 2'b00);
      ar_send(32'h20, 2'b01, 3'd3, 8'd3, 8'h22);
      rd_collect(3);
      chk("wrap_w20", rd[0], 64'hB0B0_0000_0000_0001);
      chk("wrap_w28", rd[1], 64'hB0B0_0000_0000_0002);
      chk("wrap_w30", rd[2], 64'hB0B0_0000_0000_0003);
      chk("wrap_w38", rd[3], 64'hB0B0_0000_0000_0000);

      // narrow 4-byte INCR from 0x04 over preset words 0..2
      wd[0] = 64'h1111_1111_2222_2222;
      wd[1] = 64'h3333_3333_4444_4444;
      wd[2] = 64'h5555_5555_6666_6666;
      ws[0] = 8'hFF; ws[1] = 8'hFF; ws[2] = 8'hFF;
      wr_burst(32'h0, 2'b01, 3'd3, 8'd2, 8'h30, 2'b00);
      for (int i = 0; i < 4; i++) begin
         wd[i] = {32'hAAAA_0000 + 32'(i), 32'hAAAA_0000 + 32'(i)};
         ws[i] = (i % 2 == 0) ? 8'hF0 : 8'h0F;
      end
      wr_burst(32'h04, 2'b01, 3'd2, 8'd3, 8'h31, 2'b00);
      exp_w[0] = 64'hAAAA_0000_2222_2222;
      exp_w[1] = 64'hAAAA_0002_AAAA_0001;
      exp_w[2] = 64'h5555_5555_AAAA_0003;
      ar_send(32'h0, 2'b01, 3'd3, 8'd2, 8'h32);
      rd_collect(2);
      for (int i = 0; i < 3; i++)
         chk("narrow_wr_word", rd[i], exp_w[i]);
      ar_send(32'h04, 2'b01, 3'd2, 8'd3, 8'h33);
      rd_collect(3);
      chk("narrow_rd_b0", rd[0], exp_w[0]);
      chk("narrow_rd_b1", rd[1], exp_w[1]);
      chk("narrow_rd_b2", rd[2], exp_w[1]);
      chk("narrow_rd_b3", rd[3], exp_w[2]);

      // len=7 read with r_ready toggling 1-0-1-0
      for (int i = 0; i < 8; i++) begin
         wd[i] = 64'hE000_0000_0000_0000 + 64'(i); ws[i] = 8'hFF;
      end
      wr_burst(32'h200, 2'b01, 3'd3, 8'd7, 8'h40, 2'b00);
      ar_send(32'h200, 2'b01, 3'd3, 8'd7, 8'h41);
      k = 0;
      have_prev = 1'b0;
      prev = '0;
      for (int c = 0; c < 60 && k < 8; c++) begin
         axi_r_ready = (c % 2 == 0);
         if (axi_r_valid) begin
            if (have_prev)
               chk("stall_stable", axi_r_data, prev);
            have_prev = 1'b0;
            if (axi_r_ready) begin
               chk("tog_data", axi_r_data,
                   64'hE000_0000_0000_0000 + 64'(k));
               chk("tog_last", 64'(axi_r_last), 64'(k == 7));
               k++;
            end else begin
               prev = axi_r_data;
               have_prev = 1'b1;
            end
         end
         step();
      end
      axi_r_ready = 1'b0;
      chk("tog_count", 64'(k), 64'd8);
      chk("tog_drained", 64'(axi_r_valid), 64'd0);

      // B backpressure, then FIXED burst accepted after B handshake
      aw_send(32'h300, 2'b01, 3'd3, 8'd0, 8'h77);
      w_send(64'h7777, 8'hFF, 1'b1);
      axi_aw_addr = 32'h300; axi_aw_burst = 2'b00; axi_aw_size = 3'd3;
      axi_aw_len = 8'd1; axi_aw_id = 8'h78; axi_aw_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_b_valid", 64'(axi_b_valid), 64'd1);
         chk("bp_b_id", 64'(axi_b_id), 64'h77);
         chk("bp_aw_ready", 64'(axi_aw_ready), 64'd0);
         step();
      end
      axi_b_ready = 1'b1;
      step();
      axi_b_ready = 1'b0;
      chk("bp_b_done", 64'(axi_b_valid), 64'd0);
      chk("bp_aw_ready_after", 64'(axi_aw_ready), 64'd1);
      step();
      axi_aw_valid = 1'b0;
      w_send(64'hF0F0_0000_0000_0000, 8'hFF, 1'b0);
      w_send(64'hF1F1_0000_0000_0001, 8'hFF, 1'b1);
      b_wait(8'h78, 2'b00);
      ar_send(32'h300, 2'b00, 3'd3, 8'd1, 8'h79);
      rd_collect(1);
      chk("fixed_b0", rd[0], 64'hF1F1_0000_0000_0001);
      chk("fixed_b1", rd[1], 64'hF1F1_0000_0000_0001);

      // address beyond memory size
      ar_send(32'h1100, 2'b01, 3'd3, 8'd0, 8'h50);
      rd_collect(0);
`ifdef AXI_SDP_RAM_ERR_RESP_EN
      chk("oor_rd_data", rd[0], 64'd0);
      chk("oor_rd_resp", 64'(rr[0]), 64'd2);
      wd[0] = 64'hDEAD_BEEF_DEAD_BEEF; ws[0] = 8'hFF;
      wr_burst(32'h1000, 2'b01, 3'd3, 8'd0, 8'h51, 2'b10);
      ar_send(32'h0, 2'b01, 3'd3, 8'd0, 8'h52);
      rd_collect(0);
      chk("oor_wr_untouched", rd[0], exp_w[0]);
      chk("oor_ok_resp", 64'(rr[0]), 64'd0);
`else
      chk("alias_rd_data", rd[0], 64'hA5A5_0000_0000_0020);
      chk("alias_rd_resp", 64'(rr[0]), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
